// File: rtl/exmem_pipe.sv
// EX/MEM pipeline register: captures execute results under stall/flush control and exports
// registered branch-resolution and forwarding qualifiers. Define EXMEM_STALL_CNT_EN for the stall counter.
module exmem_pipe #(
    parameter int DATA_W       = 32,
    parameter int REG_W        = 5,
    parameter int WB_W         = 2,
    parameter int M_W          = 3,
    parameter int BRANCH_BIT   = 0,
    parameter int REGWRITE_BIT = 0,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              ValidIn,
    input  logic [0:WB_W-1]   WBIn,
    input  logic [0:M_W-1]    MIn,
    input  logic [0:DATA_W-1] ALUResult,
    input  logic [0:DATA_W-1] AddResult,
    input  logic              ZeroIn,
    input  logic [0:DATA_W-1] RDIn2,
    input  logic [0:REG_W-1]  MuxIn,
    output logic              ValidOut,
    output logic [0:WB_W-1]   WBOut,
    output logic [0:M_W-1]    MOut,
    output logic [0:DATA_W-1] ALUResultOut,
    output logic [0:DATA_W-1] AddResultOut,
    output logic              ZeroOut,
    output logic [0:DATA_W-1] RDOut2,
    output logic [0:REG_W-1]  MuxOut,
    output logic              BranchTaken,
    output logic              FwdValid
`ifdef EXMEM_STALL_CNT_EN
    ,
    output logic [0:CNT_W-1]  StallCount
`endif
);

    if (BRANCH_BIT < 0 || BRANCH_BIT >= M_W || REGWRITE_BIT < 0 || REGWRITE_BIT >= WB_W ||
        DATA_W < 1 || REG_W < 1 || CNT_W < 1) begin : g_bad_params
        $error("exmem_pipe: inconsistent parameter set");
    end

    logic              valid_p0;
    logic [0:WB_W-1]   wb_p0;
    logic [0:M_W-1]    m_p0;
    logic              zero_p0;
    logic [0:DATA_W-1] alu_p0;
    logic [0:DATA_W-1] add_p0;
    logic [0:DATA_W-1] rd2_p0;
    logic [0:REG_W-1]  dst_p0;

    logic [0:WB_W-1]   wb_gated;
    logic [0:M_W-1]    m_gated;
    logic              zero_gated;

    // A non-instruction in EX must enter MEM with all side-effect controls cleared.
    always_comb begin
        wb_gated   = '0;
        m_gated    = '0;
        zero_gated = 1'b0;
        if (ValidIn) begin
            wb_gated   = WBIn;
            m_gated    = MIn;
            zero_gated = ZeroIn;
        end
    end

    // ---- EX -> MEM boundary: control fields (flush clears them, data fields keep) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_p0 <= 1'b0;
            wb_p0    <= '0;
            m_p0     <= '0;
            zero_p0  <= 1'b0;
        end else if (Flush) begin
            valid_p0 <= 1'b0;
            wb_p0    <= '0;
            m_p0     <= '0;
            zero_p0  <= 1'b0;
        end else if (!Stall) begin
            valid_p0 <= ValidIn;
            wb_p0    <= wb_gated;
            m_p0     <= m_gated;
            zero_p0  <= zero_gated;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_p0 <= '0;
            add_p0 <= '0;
            rd2_p0 <= '0;
            dst_p0 <= '0;
        end else if (!Flush && !Stall) begin
            alu_p0 <= ALUResult;
            add_p0 <= AddResult;
            rd2_p0 <= RDIn2;
            dst_p0 <= MuxIn;
        end
    end

    assign ValidOut     = valid_p0;
    assign WBOut        = wb_p0;
    assign MOut         = m_p0;
    assign ZeroOut      = zero_p0;
    assign ALUResultOut = alu_p0;
    assign AddResultOut = add_p0;
    assign RDOut2       = rd2_p0;
    assign MuxOut       = dst_p0;

    // Qualifiers derive only from registered state, so no input-to-output path exists.
    assign BranchTaken = valid_p0 & m_p0[BRANCH_BIT] & zero_p0;
    assign FwdValid    = valid_p0 & wb_p0[REGWRITE_BIT] & (dst_p0 != '0);

`ifdef EXMEM_STALL_CNT_EN
    logic [0:CNT_W-1] stall_cnt_p0;

    // Saturating: a long stall pins the counter at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_p0 <= '0;
        end else if (Stall && !Flush && (stall_cnt_p0 != {CNT_W{1'b1}})) begin
            stall_cnt_p0 <= stall_cnt_p0 + CNT_W'(1);
        end
    end

    assign StallCount = stall_cnt_p0;
`endif

endmodule

// File: tb/tb_exmem_pipe.sv
// Self-checking bench for exmem_pipe: directed scenarios plus randomized traffic against a
// field-level reference model. Saturation checks run only when EXMEM_STALL_CNT_EN is defined.
module tb_exmem_pipe;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int WB_W   = 2;
    localparam int M_W    = 3;
    localparam int CNT_W  = 16;
    localparam int VW     = 1 + WB_W + M_W + 3 * DATA_W + 1 + REG_W + 2;

    logic              clk = 1'b0;
    logic              rst, Stall, Flush, ValidIn, ZeroIn;
    logic [0:WB_W-1]   WBIn;
    logic [0:M_W-1]    MIn;
    logic [0:DATA_W-1] ALUResult, AddResult, RDIn2;
    logic [0:REG_W-1]  MuxIn;
    logic              ValidOut, ZeroOut, BranchTaken, FwdValid;
    logic [0:WB_W-1]   WBOut;
    logic [0:M_W-1]    MOut;
    logic [0:DATA_W-1] ALUResultOut, AddResultOut, RDOut2;
    logic [0:REG_W-1]  MuxOut;

    int checks = 0;
    int errors = 0;

    // Reference state, one variable per architectural field.
    logic              e_valid, e_zero;
    logic [0:WB_W-1]   e_wb;
    logic [0:M_W-1]    e_m;
    logic [0:DATA_W-1] e_alu, e_add, e_rd2;
    logic [0:REG_W-1]  e_dst;
    int                e_cnt;

    always #5 clk = ~clk;

`ifdef EXMEM_STALL_CNT_EN
    logic [0:CNT_W-1]  StallCount;
    logic              s_valid, s_zero, s_bt, s_fwd;
    logic [0:WB_W-1]   s_wb;
    logic [0:M_W-1]    s_m;
    logic [0:DATA_W-1] s_alu, s_add, s_rd2;
    logic [0:REG_W-1]  s_dst;
    logic [0:1]        s_cnt;

    exmem_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .WB_W(WB_W), .M_W(M_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
        .WBIn(WBIn), .MIn(MIn), .ALUResult(ALUResult), .AddResult(AddResult), .ZeroIn(ZeroIn),
        .RDIn2(RDIn2), .MuxIn(MuxIn), .ValidOut(s_valid), .WBOut(s_wb), .MOut(s_m),
        .ALUResultOut(s_alu), .AddResultOut(s_add), .ZeroOut(s_zero), .RDOut2(s_rd2),
        .MuxOut(s_dst), .BranchTaken(s_bt), .FwdValid(s_fwd), .StallCount(s_cnt));
`endif

    exmem_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .WB_W(WB_W), .M_W(M_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
        .WBIn(WBIn), .MIn(MIn), .ALUResult(ALUResult), .AddResult(AddResult), .ZeroIn(ZeroIn),
        .RDIn2(RDIn2), .MuxIn(MuxIn), .ValidOut(ValidOut), .WBOut(WBOut), .MOut(MOut),
        .ALUResultOut(ALUResultOut), .AddResultOut(AddResultOut), .ZeroOut(ZeroOut),
        .RDOut2(RDOut2), .MuxOut(MuxOut), .BranchTaken(BranchTaken), .FwdValid(FwdValid)
`ifdef EXMEM_STALL_CNT_EN
        , .StallCount(StallCount)
`endif
    );

    // Next state from the operational rules: reset, then bubble, then hold, then capture.
    task automatic model_edge();
        if (rst) begin
            {e_valid, e_wb, e_m, e_zero} = '0;
            {e_alu, e_add, e_rd2, e_dst} = '0;
            e_cnt = 0;
        end else if (Flush) begin
            {e_valid, e_wb, e_m, e_zero} = '0;
        end else if (Stall) begin
            if (e_cnt < (1 << CNT_W) - 1) e_cnt = e_cnt + 1;
        end else begin
            e_valid = ValidIn;
            e_wb    = ValidIn ? WBIn : '0;
            e_m     = ValidIn ? MIn : '0;
            e_zero  = ValidIn ? ZeroIn : 1'b0;
            e_alu   = ALUResult;
            e_add   = AddResult;
            e_rd2   = RDIn2;
            e_dst   = MuxIn;
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic bt, fwd;
        bt  = e_valid && e_m[0] && e_zero;
        fwd = e_valid && e_wb[0] && (e_dst != 0);
        return {e_valid, e_wb, e_m, e_alu, e_add, e_zero, e_rd2, e_dst, bt, fwd};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {ValidOut, WBOut, MOut, ALUResultOut, AddResultOut, ZeroOut, RDOut2, MuxOut,
                BranchTaken, FwdValid};
    endfunction

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        ValidIn   = 1'($urandom);
        WBIn      = WB_W'($urandom);
        MIn       = M_W'($urandom);
        ZeroIn    = 1'($urandom);
        ALUResult = $urandom;
        AddResult = $urandom;
        RDIn2     = $urandom;
        MuxIn     = REG_W'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            Stall = 1'($urandom);
            Flush = 1'($urandom);
            cycle();
            checks++;
            if (dut_vec() !== '0) begin
                errors++;
                $display("FAIL reset_outputs got %h exp 0", dut_vec());
            end
        end
`ifdef EXMEM_STALL_CNT_EN
        checks++;
        if (StallCount !== '0) begin
            errors++;
            $display("FAIL reset_count got %0d exp 0", StallCount);
        end
`endif
        rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
    endtask

    task automatic test_branch_load();
        ValidIn = 1'b1; WBIn = 2'b10; MIn = 3'b100; ZeroIn = 1'b1;
        ALUResult = 32'h1234_5678; AddResult = 32'h0000_0040; RDIn2 = 32'hCAFE_0001; MuxIn = 5'd8;
        cycle();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL branch_load got %h exp %h", dut_vec(), exp_vec());
        end
        checks++;
        if ({BranchTaken, FwdValid, AddResultOut, MuxOut} !== {1'b1, 1'b1, 32'h0000_0040, 5'd8}) begin
            errors++;
            $display("FAIL branch_flags got bt=%b fwd=%b add=%h dst=%0d exp bt=1 fwd=1 add=40 dst=8",
                     BranchTaken, FwdValid, AddResultOut, MuxOut);
        end
    endtask

    task automatic test_stall();
        logic [VW-1:0] held;
        int cnt0;
        ValidIn = 1'b1;
        rand_inputs(); ValidIn = 1'b1;
        cycle();
        held = dut_vec();
        cnt0 = e_cnt;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            cycle();
            checks++;
            if (dut_vec() !== held || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall_hold_%0d got %h exp %h", i, dut_vec(), held);
            end
        end
`ifdef EXMEM_STALL_CNT_EN
        checks++;
        if (int'(StallCount) !== cnt0 + 3) begin
            errors++;
            $display("FAIL stall_count got %0d exp %0d", StallCount, cnt0 + 3);
        end
`endif
        Stall = 1'b0;
        rand_inputs(); ValidIn = 1'b1;
        cycle();
        checks++;
        if (dut_vec() !== exp_vec() || ALUResultOut !== ALUResult) begin
            errors++;
            $display("FAIL stall_release got %h exp %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_flush_stall();
        logic [0:DATA_W-1] alu_before;
        int cnt0;
        rand_inputs();
        ValidIn = 1'b1; MIn = 3'b100; ZeroIn = 1'b1; WBIn = 2'b10;
        cycle();
        alu_before = ALUResultOut;
        cnt0 = e_cnt;
        checks++;
        if (BranchTaken !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup_bt got %b exp 1", BranchTaken);
        end
        rand_inputs();
        Flush = 1'b1; Stall = 1'b1;
        cycle();
        checks++;
        if ({ValidOut, MOut, WBOut, ZeroOut, BranchTaken, FwdValid} !== '0 ||
            ALUResultOut !== alu_before || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL flush_bubble got %h exp %h", dut_vec(), exp_vec());
        end
`ifdef EXMEM_STALL_CNT_EN
        checks++;
        if (int'(StallCount) !== cnt0) begin
            errors++;
            $display("FAIL flush_count got %0d exp %0d", StallCount, cnt0);
        end
`endif
        Flush = 1'b0; Stall = 1'b0;
    endtask

    task automatic test_bubble_and_r0();
        rand_inputs();
        ValidIn = 1'b0; WBIn = 2'b11; MIn = 3'b111; ZeroIn = 1'b1;
        cycle();
        checks++;
        if ({ValidOut, WBOut, MOut, ZeroOut, BranchTaken, FwdValid} !== '0 ||
            dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL invalid_gating got %h exp %h", dut_vec(), exp_vec());
        end
        rand_inputs();
        ValidIn = 1'b1; WBIn = 2'b10; MuxIn = '0;
        cycle();
        checks++;
        if (FwdValid !== 1'b0 || ValidOut !== 1'b1) begin
            errors++;
            $display("FAIL fwd_r0 got fwd=%b vld=%b exp fwd=0 vld=1", FwdValid, ValidOut);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            Stall = ($urandom_range(0, 3) == 0);
            Flush = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            cycle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
`ifdef EXMEM_STALL_CNT_EN
            checks++;
            if (int'(StallCount) !== e_cnt) begin
                errors++;
                $display("FAIL random_count_%0d got %0d exp %0d", i, StallCount, e_cnt);
            end
`endif
        end
        rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
    endtask

`ifdef EXMEM_STALL_CNT_EN
    task automatic test_saturation();
        int exp_seq[5] = '{1, 2, 3, 3, 3};
        rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        cycle();
        rst = 1'b0; Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            cycle();
            checks++;
            if (int'(s_cnt) !== exp_seq[i]) begin
                errors++;
                $display("FAIL sat_count_%0d got %0d exp %0d", i, s_cnt, exp_seq[i]);
            end
        end
        rst = 1'b1;
        cycle();
        checks++;
        if (s_cnt !== 2'd0) begin
            errors++;
            $display("FAIL sat_reset got %0d exp 0", s_cnt);
        end
        rst = 1'b0; Stall = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        rand_inputs();
        e_cnt = 0;
        {e_valid, e_wb, e_m, e_zero, e_alu, e_add, e_rd2, e_dst} = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_branch_load();
        test_stall();
        test_flush_stall();
        test_bubble_and_r0();
        test_random();
`ifdef EXMEM_STALL_CNT_EN
        test_saturation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
